// File: rtl/seq_alu.sv
// Handshaked execute unit: 1-cycle ALU ops plus iterative MUL/MULHU/DIVU/REMU.
// Latency 1 (single-cycle/illegal) or WIDTH+1 (mul/div); accepts only in IDLE, holds result until out_ready.
module seq_alu #(
   parameter int WIDTH  = 32,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALUControl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Result,
   output logic             Carry,
   output logic             OverFlow,
   output logic             Zero,
   output logic             Negative,
   output logic             op_err
);
   localparam int SW = $clog2(WIDTH);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, EXEC1, BUSY, DONE} state_t;

   state_t             state_q;
   logic [WIDTH-1:0]   a_q, b_q, result_q;
   logic [3:0]         op_q;
   logic [2*WIDTH-1:0] prod_q, step_d;
   logic [CW-1:0]      cnt_q;
   logic               in_ready_q, out_valid_q;
   logic               carry_q, ovf_q, zero_q, neg_q, err_q;

   logic [WIDTH:0]     sum, diff, mul_hi, div_sh, div_trial;
   logic               add_ovf, sub_ovf, muldiv_in;
   logic [SW-1:0]      shamt;
   logic [WIDTH-1:0]   res_d;
   logic               carry_d, ovf_d, err_d;

   assign sum     = {1'b0, a_q} + {1'b0, b_q};
   assign diff    = {1'b0, a_q} - {1'b0, b_q};
   assign add_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
   assign sub_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
   assign shamt   = b_q[SW-1:0];
   assign muldiv_in = MUL_EN && ((ALUControl[3:1] == 3'b101) || (ALUControl[3:1] == 3'b110));

   // prod_q is {acc_hi, multiplier} for MUL and {remainder, dividend/quotient} for DIV
   always_comb begin
      mul_hi    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
      div_sh    = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
      div_trial = div_sh - {1'b0, b_q};
      if (op_q[3:1] == 3'b101)
         step_d = {mul_hi, prod_q[WIDTH-1:1]};
      else if (div_trial[WIDTH])
         step_d = {div_sh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
      else
         step_d = {div_trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
   end

   always_comb begin
      res_d   = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      err_d   = 1'b0;
      case (op_q)
         4'h0: begin res_d = sum[WIDTH-1:0];  carry_d = sum[WIDTH];  ovf_d = add_ovf; end
         4'h1: begin res_d = diff[WIDTH-1:0]; carry_d = diff[WIDTH]; ovf_d = sub_ovf; end
         4'h2: res_d = a_q & b_q;
         4'h3: res_d = a_q | b_q;
         4'h4: res_d = a_q ^ b_q;
         4'h5: res_d = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
         4'h6: res_d = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
         4'h7: res_d = a_q << shamt;
         4'h8: res_d = a_q >> shamt;
         4'h9: res_d = $signed(a_q) >>> shamt;
         4'hA, 4'hC: if (MUL_EN) res_d = prod_q[WIDTH-1:0];       else err_d = 1'b1;
         4'hB, 4'hD: if (MUL_EN) res_d = prod_q[2*WIDTH-1:WIDTH]; else err_d = 1'b1;
         default: err_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         prod_q      <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               a_q        <= A;
               b_q        <= B;
               op_q       <= ALUControl;
               cnt_q      <= '0;
               in_ready_q <= 1'b0;
               prod_q     <= (ALUControl[3:1] == 3'b101) ? {{WIDTH{1'b0}}, B} : {{WIDTH{1'b0}}, A};
               state_q    <= muldiv_in ? BUSY : EXEC1;
            end
            BUSY: if (cnt_q != CW'(WIDTH)) begin
               prod_q <= step_d;
               cnt_q  <= cnt_q + CW'(1);
            end
            DONE: if (out_ready) begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
            default: ;
         endcase
         // one extra BUSY cycle after the last iteration registers the result
         if (state_q == EXEC1 || (state_q == BUSY && cnt_q == CW'(WIDTH))) begin
            result_q    <= res_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            zero_q      <= (res_d == '0);
            neg_q       <= res_d[WIDTH-1];
            err_q       <= err_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign Result    = result_q;
   assign Carry     = carry_q;
   assign OverFlow  = ovf_q;
   assign Zero      = zero_q;
   assign Negative  = neg_q;
   assign op_err    = err_q;
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed vector table, randomized ops against a reference model, backpressure and reset sequences.
module tb_seq_alu;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] A, B, Result;
   logic [3:0]  ALUControl;
   logic        Carry, OverFlow, Zero, Negative, op_err;

   int checks = 0;
   int errors = 0;

   seq_alu #(.WIDTH(32), .MUL_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .ALUControl(ALUControl), .out_valid(out_valid), .out_ready(out_ready),
      .Result(Result), .Carry(Carry), .OverFlow(OverFlow), .Zero(Zero),
      .Negative(Negative), .op_err(op_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a, b;
      logic [3:0]  op;
      logic [31:0] res;
      logic [4:0]  fl;   // {Carry, OverFlow, Zero, Negative, op_err}
      int          lat;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [4:0] flags();
      return {Carry, OverFlow, Zero, Negative, op_err};
   endfunction

   // Reference model: plain 64-bit arithmetic from the operation definitions
   function automatic logic [36:0] ref_model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      longint unsigned ua, ub, p;
      longint          sa, sb, s;
      logic [31:0]     r;
      logic [4:0]      sh;
      logic            c, v, e;
      ua = {32'b0, a}; ub = {32'b0, b};
      sa = $signed(a); sb = $signed(b);
      sh = b[4:0];
      r = '0; c = 1'b0; v = 1'b0; e = 1'b0;
      case (op)
         4'h0: begin p = ua + ub; r = p[31:0]; c = p > 64'd4294967295;
                     s = sa + sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         4'h1: begin r = a - b; c = a < b;
                     s = sa - sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         4'h2: r = a & b;
         4'h3: r = a | b;
         4'h4: r = a ^ b;
         4'h5: r = (sa < sb) ? 32'd1 : 32'd0;
         4'h6: r = (a < b) ? 32'd1 : 32'd0;
         4'h7: r = a << sh;
         4'h8: r = a >> sh;
         4'h9: begin s = sa >>> sh; r = s[31:0]; end
         4'hA: begin p = ua * ub; r = p[31:0]; end
         4'hB: begin p = ua * ub; r = p[63:32]; end
         4'hC: r = (b == 0) ? 32'hFFFFFFFF : a / b;
         4'hD: r = (b == 0) ? a : a % b;
         default: e = 1'b1;
      endcase
      return {r, c, v, (r == 0), r[31], e};
   endfunction

   // Issue one op, wait for the result, then complete the output handshake.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        output logic [31:0] res, output logic [4:0] fl, output int lat);
      int w;
      logic busy_ok;
      w = 0;
      while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
      chk("in_ready_before_issue", in_ready, 1'b1);
      A = a; B = b; ALUControl = op; in_valid = 1'b1;
      @(posedge clk); #1;
      // scramble inputs and keep in_valid high: both must be ignored while busy
      A = $urandom; B = $urandom; ALUControl = 4'($urandom);
      lat = 0; busy_ok = 1'b1;
      while (!out_valid && lat < 100) begin
         if (in_ready) busy_ok = 1'b0;
         @(posedge clk); #1; lat++;
      end
      chk("in_ready_low_while_busy", busy_ok, 1'b1);
      res = Result; fl = flags();
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("out_valid_drops_after_hs", out_valid, 1'b0);
      chk("in_ready_after_hs", in_ready, 1'b1);
      chk("result_kept_after_hs", Result, res);
   endtask

   initial begin
      vec_t        vecs[18];
      logic [31:0] r, hold;
      logic [4:0]  f;
      logic [36:0] m;
      logic [31:0] ra, rb;
      logic [3:0]  rop;
      int          lat, w;

      vecs[0]  = '{32'h7FFFFFFF, 32'h1,        4'h0, 32'h80000000, 5'b01010, 1};
      vecs[1]  = '{32'h0,        32'h1,        4'h1, 32'hFFFFFFFF, 5'b10010, 1};
      vecs[2]  = '{32'h80000000, 32'h7FFFFFFF, 4'h5, 32'h1,        5'b00000, 1};
      vecs[3]  = '{32'h80000000, 32'h7FFFFFFF, 4'h6, 32'h0,        5'b00100, 1};
      vecs[4]  = '{32'h80000000, 32'h1F,       4'h9, 32'hFFFFFFFF, 5'b00010, 1};
      vecs[5]  = '{32'hFFFFFFFF, 32'h2,        4'hA, 32'hFFFFFFFE, 5'b00010, 33};
      vecs[6]  = '{32'hFFFFFFFF, 32'h2,        4'hB, 32'h1,        5'b00000, 33};
      vecs[7]  = '{32'h64,       32'h7,        4'hC, 32'hE,        5'b00000, 33};
      vecs[8]  = '{32'h64,       32'h7,        4'hD, 32'h2,        5'b00000, 33};
      vecs[9]  = '{32'h12345,    32'h0,        4'hC, 32'hFFFFFFFF, 5'b00010, 33};
      vecs[10] = '{32'h5,        32'h0,        4'hD, 32'h5,        5'b00000, 33};
      vecs[11] = '{32'h1,        32'h2,        4'hF, 32'h0,        5'b00101, 1};
      vecs[12] = '{32'h5,        32'h3,        4'hE, 32'h0,        5'b00101, 1};
      vecs[13] = '{32'hFFFFFFFF, 32'h1,        4'h0, 32'h0,        5'b10100, 1};
      vecs[14] = '{32'h80000000, 32'h1,        4'h1, 32'h7FFFFFFF, 5'b01000, 1};
      vecs[15] = '{32'h1,        32'h1F,       4'h7, 32'h80000000, 5'b00010, 1};
      vecs[16] = '{32'h80000000, 32'hFFFFFFFF, 4'h8, 32'h1,        5'b00000, 1};
      vecs[17] = '{32'h0000F0F0, 32'h0000FF00, 4'h4, 32'h00000FF0, 5'b00000, 1};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; ALUControl = '0;
      #1;
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_in_ready", in_ready, 1'b1);
      chk("reset_result", Result, 32'h0);
      chk("reset_flags", flags(), 5'b0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].op, r, f, lat);
         chk($sformatf("vec%0d_result", i), r, vecs[i].res);
         chk($sformatf("vec%0d_flags", i), f, vecs[i].fl);
         chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      end

      for (int i = 0; i < 200; i++) begin
         ra  = $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         rop = 4'($urandom_range(0, 15));
         if (i % 7 == 0) ra = 32'h80000000 | 32'($urandom_range(0, 3));
         m = ref_model(ra, rb, rop);
         do_op(ra, rb, rop, r, f, lat);
         chk($sformatf("rand%0d_op%0h_result", i, rop), r, m[36:5]);
         chk($sformatf("rand%0d_op%0h_flags", i, rop), f, m[4:0]);
         chk($sformatf("rand%0d_op%0h_latency", i, rop), lat, (rop >= 4'hA && rop <= 4'hD) ? 33 : 1);
      end

      // Backpressure: result must stay put while out_ready is low
      A = 32'h11111111; B = 32'h22222222; ALUControl = 4'h0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 100) begin @(posedge clk); #1; w++; end
      chk("bp_out_valid", out_valid, 1'b1);
      hold = Result;
      chk("bp_result", hold, 32'h33333333);
      A = 32'h5; B = 32'h6; ALUControl = 4'h1; in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk($sformatf("bp_stable%0d", k), Result, hold);
         chk($sformatf("bp_in_ready%0d", k), in_ready, 1'b0);
         chk($sformatf("bp_valid%0d", k), out_valid, 1'b1);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_release_valid", out_valid, 1'b0);
      chk("bp_release_ready", in_ready, 1'b1);

      // Reset pulsed mid-multiply discards the op and clears outputs
      A = 32'h1234; B = 32'h5678; ALUControl = 4'hA; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      chk("busy_before_rst", in_ready, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_busy_out_valid", out_valid, 1'b0);
      chk("rst_busy_in_ready", in_ready, 1'b1);
      chk("rst_busy_result", Result, 32'h0);
      chk("rst_busy_flags", flags(), 5'b0);
      rst = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk("rst_op_discarded", out_valid, 1'b0);
      do_op(32'h2, 32'h3, 4'h0, r, f, lat);
      chk("post_rst_add", r, 32'h5);
      chk("post_rst_latency", lat, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
